caesar_cg_ctrl: RTL
===================

CAESAR_CG_CTRL -- requirements
Module: caesar_cg_ctrl

Interface
REQ-001 Parameter NumCh, default 4: number of independently gated clock channels, range 1..32.
REQ-002 Parameter IdleCntW, default 8: width of the idle counter and of the threshold input.
REQ-003 Parameter WakeCycles, default 2: cycles held in WAKE before RUN, range 1..15.
REQ-004 clk_i  input  1  free-running source clock; all state is in this domain.
REQ-005 rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 scan_cg_en_i  input  1  scan/test enable; forces every gated clock on.
REQ-007 cfg_auto_en_i  input  NumCh  per-channel automatic gating enable.
REQ-008 cfg_force_on_i  input  NumCh  per-channel force-on; overrides auto gating.
REQ-009 cfg_idle_thr_i  input  IdleCntW  consecutive idle cycles before gating; 0 disables gating.
REQ-010 busy_i  input  NumCh  per-channel activity flag, clk_i domain.
REQ-011 wake_req_i  input  NumCh  per-channel four-phase wake request.
REQ-012 wake_ack_o  output  NumCh  per-channel wake acknowledge, registered.
REQ-013 clk_en_o  output  NumCh  registered per-channel enable; status copy of the gate-cell enable.
REQ-014 clk_o  output  NumCh  per-channel gated clocks.

Function
REQ-015 Each channel SHALL run an independent FSM with states RUN, IDLE, GATED and WAKE.
REQ-016 A channel's idle condition SHALL be: cfg_auto_en_i=1, cfg_force_on_i=0, busy_i=0, wake_req_i=0 and cfg_idle_thr_i!=0.
REQ-017 RUN: clk_en=1; on idle condition -> IDLE with cnt:=1; otherwise stay, cnt:=0.
REQ-018 IDLE: clk_en=1; idle condition lost -> RUN, cnt:=0; else if cnt>=cfg_idle_thr_i -> GATED; else cnt:=cnt+1.
REQ-019 The threshold SHALL be compared live each cycle, so a lowered threshold mid-count gates on the next cycle.
REQ-020 GATED: clk_en=0; when idle condition is false -> WAKE, cnt:=0, and clk_en=1 from the next cycle.
REQ-021 WAKE: clk_en=1; cnt increments; after exactly WakeCycles cycles in WAKE -> RUN.
REQ-022 Wake requests, busy or force arriving during WAKE SHALL NOT shorten or extend WAKE.
REQ-023 wake_ack_o SHALL be a flop set to (state==RUN and wake_req_i=1), giving one cycle of latency.
REQ-024 The requester holds wake_req_i until ack is seen, then drops it; ack drops one cycle later.
REQ-025 While wake_req_i=1 the channel SHALL NOT leave RUN.
REQ-026 Each gate cell SHALL receive clk_en_o[i] as enable and scan_cg_en_i as test enable.
REQ-027 clk_o[i] SHALL be glitch-free, with gating only through the latch-based cell.
REQ-028 scan_cg_en_i SHALL NOT alter FSM state.
REQ-029 cnt SHALL saturate at its maximum value and never wrap.
REQ-030 Simultaneous deassertion of cfg_auto_en_i and the threshold being reached SHALL resolve to RUN, not GATED.

Reset
REQ-031 Asserting rst_ni SHALL asynchronously force every channel to RUN with cnt=0, clk_en_o all 1 and wake_ack_o all 0.
REQ-032 Reset mid-GATED or mid-WAKE SHALL immediately re-enable clocks.
REQ-033 Deassertion of rst_ni SHALL be synchronised externally.

Structure
REQ-034 Package caesar_cg_pkg SHALL hold the cg_state_e enum (RUN, IDLE, GATED, WAKE) and default parameter constants.
REQ-035 Sub-module caesar_cg_channel SHALL implement one channel's FSM, counter and ack flop.
REQ-036 The top SHALL instantiate NumCh caesar_cg_channel instances plus NumCh gf22_clk_gating cells.

Verification
REQ-037 Auto gating: thr=4, auto=1, busy=0 from cycle 0 -> clk_en_o[0] falls exactly 5 cycles after leaving RUN; clk_o[0] then stops toggling.
REQ-038 Busy wake: channel GATED, busy_i pulses 1 cycle -> clk_en_o high the next cycle, WAKE lasts 2 cycles, then RUN.
REQ-039 Wake handshake: channel GATED, wake_req raised -> wake_ack_o rises 1 cycle after RUN is entered; req drop -> ack drops 1 cycle later; no re-gating while req is high.
REQ-040 Boundaries: thr=0 -> never gates; force_on=1 during IDLE -> RUN; busy during IDLE at cnt=3 -> RUN with cnt=0.
REQ-041 Reset mid-GATED -> clk_en_o all 1 and wake_ack_o all 0 asynchronously.
REQ-042 Scan: scan_cg_en_i=1 with channel GATED -> clk_o toggles and state stays GATED.

Source files
------------

// File: rtl/caesar_cg_pkg.sv
// Shared state encoding and default sizing for the clock-gating controller.
// Latency: none (declarations only).
// Backpressure: none.
package caesar_cg_pkg;

    localparam int unsigned NumChDefault      = 4;
    localparam int unsigned IdleCntWDefault   = 8;
    localparam int unsigned WakeCyclesDefault = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_e;

endpackage

// File: rtl/caesar_cg_channel.sv
// One gating channel: RUN/IDLE/GATED/WAKE FSM, idle/wake counter, wake ack flop.
// Latency: clk_en and wake_ack are registered, one cycle after the deciding inputs.
// Backpressure: none; wake_req is a four-phase handshake answered only from RUN.
module caesar_cg_channel
    import caesar_cg_pkg::*;
#(
    parameter int unsigned IdleCntW   = IdleCntWDefault,
    parameter int unsigned WakeCycles = WakeCyclesDefault
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                auto_en,
    input  logic                force_on,
    input  logic [IdleCntW-1:0] idle_thr,
    input  logic                busy,
    input  logic                wake_req,
    output logic                clk_en,
    output logic                wake_ack
);

    localparam logic [IdleCntW-1:0] CntMax   = '1;
    localparam logic [IdleCntW-1:0] CntOne   = IdleCntW'(1);
    localparam logic [IdleCntW-1:0] WakeLast = IdleCntW'(WakeCycles - 1);

    cg_state_e           state_q, state_d;
    logic [IdleCntW-1:0] cnt_q, cnt_d;
    logic [IdleCntW-1:0] cnt_inc;
    logic                idle;

    // A zero threshold means "never gate", so it also counts as activity.
    assign idle    = auto_en & ~force_on & ~busy & ~wake_req & (idle_thr != '0);
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    // Next-state and counter update; loss of idle always wins over the threshold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (idle) begin
                    state_d = IDLE;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (!idle) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= idle_thr) begin
                    state_d = GATED;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            GATED: begin
                if (!idle) begin
                    state_d = WAKE;
                    cnt_d   = '0;
                end
            end
            WAKE: begin
                // Fixed-length wake window; inputs are deliberately ignored here.
                if (cnt_q >= WakeLast) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, registered enable and ack; reset re-opens the clock at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            clk_en   <= 1'b1;
            wake_ack <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_en   <= (state_d != GATED);
            wake_ack <= (state_q == RUN) && wake_req;
        end
    end

endmodule

// File: rtl/gf22_clk_gating.sv
// Latch-based integrated clock gate: enable is captured while the clock is low.
// Latency: enable change takes effect from the next rising clock edge.
// Backpressure: none; test_en_i forces the clock through regardless of en_i.
module gf22_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    // Transparent while clk_i is low so the AND below can never glitch.
    always_latch begin
        if (!clk_i) begin
            en_latch <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/caesar_cg_ctrl.sv
// Per-channel automatic clock gating controller with wake handshake and scan override.
// Latency: clk_en_o/wake_ack_o registered (1 cycle); gated clock follows on the next edge.
// Backpressure: none; scan_cg_en_i forces clocks on without touching channel state.
module caesar_cg_ctrl
    import caesar_cg_pkg::*;
#(
    parameter int unsigned NumCh      = NumChDefault,
    parameter int unsigned IdleCntW   = IdleCntWDefault,
    parameter int unsigned WakeCycles = WakeCyclesDefault
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                scan_cg_en_i,
    input  logic [NumCh-1:0]    cfg_auto_en_i,
    input  logic [NumCh-1:0]    cfg_force_on_i,
    input  logic [IdleCntW-1:0] cfg_idle_thr_i,
    input  logic [NumCh-1:0]    busy_i,
    input  logic [NumCh-1:0]    wake_req_i,
    output logic [NumCh-1:0]    wake_ack_o,
    output logic [NumCh-1:0]    clk_en_o,
    output logic [NumCh-1:0]    clk_o
);

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        caesar_cg_channel #(
            .IdleCntW   (IdleCntW),
            .WakeCycles (WakeCycles)
        ) u_channel (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .auto_en  (cfg_auto_en_i[i]),
            .force_on (cfg_force_on_i[i]),
            .idle_thr (cfg_idle_thr_i),
            .busy     (busy_i[i]),
            .wake_req (wake_req_i[i]),
            .clk_en   (clk_en_o[i]),
            .wake_ack (wake_ack_o[i])
        );

        // The gate cell sees the same registered enable that is reported on clk_en_o.
        gf22_clk_gating u_cg (
            .clk_i     (clk_i),
            .en_i      (clk_en_o[i]),
            .test_en_i (scan_cg_en_i),
            .clk_o     (clk_o[i])
        );
    end

endmodule
